dds_update_sequencer: RTL

DDS_UPDATE_SEQUENCER -- requirements
Module: dds_update_sequencer

---
 rtl/dds_seq_pkg.sv | 24 ++
 rtl/dds_update_sequencer_if.sv | 24 ++
 rtl/tvth_toggle.sv | 44 ++++
 rtl/dds_update_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS update sequencer: state encoding, timeout
// defaults and the alternate-polarisation mode code.
package dds_seq_pkg;

    localparam int unsigned DEF_BUSY_TIMEOUT = 32'd1024;
    localparam int unsigned DEF_FIN_TIMEOUT  = 32'd1000000;
    localparam int unsigned DEF_TMO_W        = 32'd20;

    localparam logic [1:0] MODE_ALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_FIN  = 3'd3,
        ST_LOAD      = 3'd4,
        ST_WAIT_REL  = 3'd5
    } seq_state_t;

    function automatic logic both_set(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/dds_update_sequencer_if.sv
// Command/update handshake bundle between the depacketiser, the sequencer
// and the two DDS controllers.
interface dds_update_sequencer_if;

    logic pkt_ready;
    logic pkt_load;
    logic upd_1;
    logic upd_2;
    logic busy_1;
    logic busy_2;
    logic finish_1;
    logic finish_2;

    modport master (
        input  pkt_ready, busy_1, busy_2, finish_1, finish_2,
        output pkt_load, upd_1, upd_2
    );

    modport slave (
        output pkt_ready, busy_1, busy_2, finish_1, finish_2,
        input  pkt_load, upd_1, upd_2
    );

endinterface

// File: rtl/tvth_toggle.sv
// Sweep-trigger edge detector and TV/TH transmit polarisation registers.
module tvth_toggle
    import dds_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       trig_in,
    output logic       tv,
    output logic       th
);

    logic trig_d_r;
    logic tv_r;
    logic th_r;
    logic rise_s;

    assign rise_s = trig_in & ~trig_d_r;

    // Outside alternate mode the pair is pinned to TV; inside it, each trigger swaps them
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_d_r <= 1'b0;
            tv_r     <= 1'b1;
            th_r     <= 1'b0;
        end else begin
            trig_d_r <= trig_in;
            if (mode != MODE_ALT) begin
                tv_r <= 1'b1;
                th_r <= 1'b0;
            end else if (rise_s) begin
                tv_r <= ~tv_r;
                th_r <= tv_r;
            end else begin
                tv_r <= tv_r;
                th_r <= th_r;
            end
        end
    end

    assign tv = tv_r;
    assign th = th_r;

endmodule

// File: rtl/dds_update_sequencer.sv
// Sequences one validated command through both DDS controllers, with
// per-phase timeouts, a success counter and the TV/TH polarisation control.
module dds_update_sequencer
    import dds_seq_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int unsigned FIN_TIMEOUT  = DEF_FIN_TIMEOUT,
    parameter int unsigned TMO_W        = DEF_TMO_W
) (
    input  logic                          clk,
    input  logic                          rst,
    dds_update_sequencer_if.master        bus,
    input  logic [1:0]                    mode,
    input  logic                          trig_in,
    output logic                          tv,
    output logic                          th,
    output logic                          err_tmo,
    input  logic                          err_clr,
    output logic [15:0]                   upd_cnt,
    output logic [2:0]                    state_dbg
);

    localparam logic [TMO_W-1:0] BUSY_LAST = TMO_W'(BUSY_TIMEOUT - 32'd1);
    localparam logic [TMO_W-1:0] FIN_LAST  = TMO_W'(FIN_TIMEOUT - 32'd1);

    seq_state_t       state_r,   state_s;
    logic             upd_1_r,   upd_1_s;
    logic             upd_2_r,   upd_2_s;
    logic             pkt_load_r, pkt_load_s;
    logic             acc_1_r,   acc_1_s;
    logic             acc_2_r,   acc_2_s;
    logic             fin_1_r,   fin_1_s;
    logic             fin_2_r,   fin_2_s;
    logic             tmo_seq_r, tmo_seq_s;
    logic             err_tmo_r, err_tmo_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [15:0]      upd_cnt_r, upd_cnt_s;
    logic             tmo_fire_s;

    // Next-state and next-output logic for the update sequence
    always_comb begin
        state_s    = state_r;
        upd_1_s    = upd_1_r;
        upd_2_s    = upd_2_r;
        pkt_load_s = pkt_load_r;
        acc_1_s    = acc_1_r;
        acc_2_s    = acc_2_r;
        fin_1_s    = fin_1_r;
        fin_2_s    = fin_2_r;
        tmo_seq_s  = tmo_seq_r;
        tmo_cnt_s  = tmo_cnt_r;
        upd_cnt_s  = upd_cnt_r;
        tmo_fire_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.pkt_ready) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                upd_1_s   = 1'b1;
                upd_2_s   = 1'b1;
                acc_1_s   = 1'b0;
                acc_2_s   = 1'b0;
                fin_1_s   = 1'b0;
                fin_2_s   = 1'b0;
                tmo_seq_s = 1'b0;
                tmo_cnt_s = '0;
                state_s   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                acc_1_s = acc_1_r | bus.busy_1;
                acc_2_s = acc_2_r | bus.busy_2;
                upd_1_s = bus.busy_1 ? 1'b0 : upd_1_r;
                upd_2_s = bus.busy_2 ? 1'b0 : upd_2_r;
                // Acceptance on the final allowed cycle still wins over the timeout
                if (both_set(acc_1_s, acc_2_s)) begin
                    state_s   = ST_WAIT_FIN;
                    tmo_cnt_s = '0;
                end else if (tmo_cnt_r == BUSY_LAST) begin
                    state_s    = ST_LOAD;
                    upd_1_s    = 1'b0;
                    upd_2_s    = 1'b0;
                    tmo_fire_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_WAIT_FIN: begin
                fin_1_s = fin_1_r | bus.finish_1;
                fin_2_s = fin_2_r | bus.finish_2;
                if (both_set(fin_1_s, fin_2_s)) begin
                    state_s = ST_LOAD;
                end else if (tmo_cnt_r == FIN_LAST) begin
                    state_s    = ST_LOAD;
                    tmo_fire_s = 1'b1;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            ST_LOAD: begin
                pkt_load_s = 1'b1;
                state_s    = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!bus.pkt_ready) begin
                    pkt_load_s = 1'b0;
                    state_s    = ST_IDLE;
                    upd_cnt_s  = tmo_seq_r ? upd_cnt_r : (upd_cnt_r + 16'd1);
                end else begin
                    state_s = ST_WAIT_REL;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                upd_1_s    = 1'b0;
                upd_2_s    = 1'b0;
                pkt_load_s = 1'b0;
            end
        endcase

        // A timeout firing this cycle beats a simultaneous clear
        if (tmo_fire_s) begin
            tmo_seq_s = 1'b1;
            err_tmo_s = 1'b1;
        end else if (err_clr) begin
            err_tmo_s = 1'b0;
        end else begin
            err_tmo_s = err_tmo_r;
        end
    end

    // Sequencer state, handshake outputs, flags and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            upd_1_r    <= 1'b0;
            upd_2_r    <= 1'b0;
            pkt_load_r <= 1'b0;
            acc_1_r    <= 1'b0;
            acc_2_r    <= 1'b0;
            fin_1_r    <= 1'b0;
            fin_2_r    <= 1'b0;
            tmo_seq_r  <= 1'b0;
            err_tmo_r  <= 1'b0;
            tmo_cnt_r  <= '0;
            upd_cnt_r  <= 16'd0;
        end else begin
            state_r    <= state_s;
            upd_1_r    <= upd_1_s;
            upd_2_r    <= upd_2_s;
            pkt_load_r <= pkt_load_s;
            acc_1_r    <= acc_1_s;
            acc_2_r    <= acc_2_s;
            fin_1_r    <= fin_1_s;
            fin_2_r    <= fin_2_s;
            tmo_seq_r  <= tmo_seq_s;
            err_tmo_r  <= err_tmo_s;
            tmo_cnt_r  <= tmo_cnt_s;
            upd_cnt_r  <= upd_cnt_s;
        end
    end

    tvth_toggle u_tvth (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .trig_in (trig_in),
        .tv      (tv),
        .th      (th)
    );

    assign bus.upd_1    = upd_1_r;
    assign bus.upd_2    = upd_2_r;
    assign bus.pkt_load = pkt_load_r;
    assign err_tmo      = err_tmo_r;
    assign upd_cnt      = upd_cnt_r;
    assign state_dbg    = state_r;

endmodule
